// File: rtl/sha3_padder_ctrl_if.sv
// sha3_padder_ctrl_if: message-word input and rate-block output handshake bundle.
interface sha3_padder_ctrl_if #(parameter int RATE_WORDS = 9);
    logic [63:0]              in;
    logic                     in_valid;
    logic                     is_last;
    logic [2:0]               byte_num;
    logic                     in_ready;
    logic                     clear;
    logic [64*RATE_WORDS-1:0] out;
    logic                     out_valid;
    logic                     out_ack;
    logic                     last_block;
    logic                     done;
    modport master (
        output in, in_valid, is_last, byte_num, clear, out_ack,
        input  in_ready, out, out_valid, last_block, done
    );
    modport slave (
        input  in, in_valid, is_last, byte_num, clear, out_ack,
        output in_ready, out, out_valid, last_block, done
    );
endinterface

// File: rtl/sha3_padder_ctrl.sv
// sha3_padder_ctrl: collects 64-bit message words into SHA3 rate blocks,
// applying 0x06..0x80 domain padding and zero fill to the final block.
module sha3_padder_ctrl #(
    parameter int RATE_WORDS = 9
) (
    input logic              clk,
    input logic              rst_n,
    sha3_padder_ctrl_if.slave bus
);
    localparam int W  = 64 * RATE_WORDS;
    localparam int CW = $clog2(RATE_WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(RATE_WORDS - 1);

    typedef enum logic [1:0] {ABSORB, PAD, FULL, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  out_q, out_d;
    logic          last_q, last_d;
    logic          at_end;
    logic [63:0]   pad_word;

    // Keep the n leading message bytes and place the 0x06 domain byte right after them.
    function automatic logic [63:0] padder1(input logic [63:0] d, input logic [2:0] n);
        logic [63:0] keep;
        keep = ~({64{1'b1}} >> {n, 3'b000});
        return (d & keep) | (64'h06 << (6'd56 - {n, 3'b000}));
    endfunction

    assign at_end   = cnt_q == LAST;
    assign pad_word = padder1(bus.in, bus.byte_num) | (at_end ? 64'h80 : 64'h0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        last_d  = last_q;
        if (bus.clear) begin
            state_d = ABSORB;
            cnt_d   = '0;
            out_d   = '0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                ABSORB: if (bus.in_valid) begin
                    out_d   = {out_q[W-65:0], bus.is_last ? pad_word : bus.in};
                    cnt_d   = cnt_q + 1'b1;
                    last_d  = last_q | bus.is_last;
                    state_d = at_end ? FULL : (bus.is_last ? PAD : ABSORB);
                end
                PAD: begin
                    out_d   = {out_q[W-65:0], at_end ? 64'h80 : 64'h0};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = at_end ? FULL : PAD;
                end
                FULL: if (bus.out_ack) begin
                    cnt_d   = '0;
                    out_d   = '0;
                    last_d  = 1'b0;
                    state_d = last_q ? DONE : ABSORB;
                end
                DONE: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ABSORB;
            cnt_q   <= '0;
            out_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready   = state_q == ABSORB;
    assign bus.out_valid  = state_q == FULL;
    assign bus.last_block = (state_q == FULL) && last_q;
    assign bus.done       = state_q == DONE;
    assign bus.out        = out_q;
endmodule
